exmem_pipe: RTL and testbench
=============================

EXMEM_PIPE -- requirements
Module: exmem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64, datapath width in bits; multiple of 16, minimum 16.
REQ-002 SHALL have parameter LOAD_LAT, default 2, dmem read latency in cycles; legal range 1..7.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports rA_data, rB_data  input  DATA_W  register-file operands; rB_data is the store data for M-type instructions.
REQ-006 SHALL have ports op_code  input  6, and ww  input  2  ALU opcode and element width, passed unchanged to the ALU.
REQ-007 SHALL have ports wr_en, mem_en, mem_wr_en  input  1 each  regfile write, memory access and memory write enables.
REQ-008 SHALL have ports fwd_rA, fwd_rB  input  1 each  select WB forwarding per operand.
REQ-009 SHALL have ports wb_data  input  DATA_W, and wb_ppp  input  3  WB write data and partial-write mode.
REQ-010 SHALL have port alu_out  output  DATA_W  ALU result to the WB stage.
REQ-011 SHALL have port mem_data_in  output  DATA_W  store data to dmem.
REQ-012 SHALL have port mem_req  output  1  one-cycle dmem access strobe.
REQ-013 SHALL have port stall  output  1  holds IF/ID and ID/EX and inserts a bubble into WB.
REQ-014 SHALL have port rd_sel  output  1  WB data select: 1 = memory, 0 = ALU.
REQ-015 SHALL have port load_cnt  output  3  current wait count, for debug.

Function
REQ-016 Bit 0 SHALL be the MSB; the halves are [0:DATA_W/2-1] (upper) and [DATA_W/2:DATA_W-1] (lower).
REQ-017 Forwarding SHALL be combinational and independent per operand; when the operand's fwd bit is 0, the operand SHALL pass through unchanged.
REQ-018 With the fwd bit set, wb_ppp SHALL select which fields come from wb_data, all other bits keeping the regfile value: 000 all bits; 001 upper half; 010 lower half; 011 even bytes (0, 2, 4, ...); 100 odd bytes; 101-111 no bits.
REQ-019 Forwarded rA and forwarded rB SHALL feed the ALU; forwarded rB SHALL drive mem_data_in.
REQ-020 A load SHALL be decoded as mem_en & wr_en & !mem_wr_en; a store SHALL be decoded as mem_en & mem_wr_en & !wr_en.
REQ-021 The FSM SHALL have exactly three states:
- IDLE
- WAIT (counting down)
- DONE (one cycle)
REQ-022 In IDLE, a decoded load SHALL assert stall and mem_req in that cycle and load load_cnt with LOAD_LAT-1; the next state SHALL be WAIT if LOAD_LAT>1, else DONE.
REQ-023 In WAIT, stall SHALL be 1 and load_cnt SHALL decrement each cycle; on load_cnt==1 the next state SHALL be DONE.
REQ-024 In DONE, stall SHALL be 0 and rd_sel SHALL be 1, and the FSM SHALL return to IDLE.
REQ-025 A load SHALL therefore see stall high for exactly LOAD_LAT cycles, with rd_sel high in the following cycle.
REQ-026 mem_req SHALL pulse for exactly one cycle per load.
REQ-027 A store SHALL assert mem_req for one cycle, SHALL NOT stall, and SHALL hold rd_sel at 0.
REQ-028 rd_sel SHALL be 1 only in DONE, or in any cycle carrying a decoded load; otherwise 0.
REQ-029 If the load decode drops while in WAIT, the FSM SHALL abort to IDLE next cycle with stall 0 that cycle.
REQ-030 A load presented in the cycle immediately after DONE SHALL start a new count with no gap cycle.
REQ-031 Forwarding SHALL operate identically during stall cycles.

Reset
REQ-032 While reset is high, the FSM SHALL go to IDLE and load_cnt to 0 at the next edge; stall, mem_req and rd_sel SHALL be 0 in the cycle after reset is sampled, including when reset arrives mid-WAIT.
REQ-033 alu_out and mem_data_in are combinational and SHALL NOT be reset.

Structure
REQ-034 The shared package SHALL hold the ppp encodings (PPP_FULL, PPP_HI, PPP_LO, PPP_EVEN, PPP_ODD), the FSM state enum, and the opcode width constant.
REQ-035 The existing alu SHALL be instantiated once; a single forward_merge sub-module (DATA_W parameter) SHALL be instantiated twice, once per operand.

Verification
REQ-036 LOAD_LAT=2, load held -> stall 1,1,0; rd_sel 0,0,1 from cycle 2 (1 from cycle 0 by decode); mem_req 1,0,0.
REQ-037 LOAD_LAT=1, load -> stall 1,0, matching the legacy single-cycle stall behaviour.
REQ-038 rA=0, wb_data=all-ones, fwd_rA=1, ppp=011 -> operand 0xFF00FF00FF00FF00; ppp=010 -> 0x00000000FFFFFFFF; ppp=111 -> 0.
REQ-039 Store with fwd_rB=1, ppp=000, wb_data=0x1234 -> mem_data_in=0x1234, mem_req 1 for one cycle, stall 0.
REQ-040 LOAD_LAT=4, reset asserted in the second WAIT cycle -> stall 0 and load_cnt 0 in the next cycle; a later load stalls a full 4 cycles.
REQ-041 Back-to-back loads with LOAD_LAT=2 -> stall pattern 1,1,0,1,1,0.

Source files
------------

// File: rtl/exmem_pipe_pkg.sv
// Shared encodings for the EX/MEM stage: forwarding field modes, ALU opcodes, FSM states.
package exmem_pipe_pkg;

   localparam int unsigned OPC_W = 6;
   localparam int unsigned PPP_W = 3;
   localparam int unsigned CNT_W = 3;

   localparam logic [PPP_W-1:0] PPP_FULL = 3'b000;
   localparam logic [PPP_W-1:0] PPP_HI   = 3'b001;
   localparam logic [PPP_W-1:0] PPP_LO   = 3'b010;
   localparam logic [PPP_W-1:0] PPP_EVEN = 3'b011;
   localparam logic [PPP_W-1:0] PPP_ODD  = 3'b100;

   localparam logic [OPC_W-1:0] OP_ADD    = 6'h00;
   localparam logic [OPC_W-1:0] OP_SUB    = 6'h01;
   localparam logic [OPC_W-1:0] OP_AND    = 6'h02;
   localparam logic [OPC_W-1:0] OP_OR     = 6'h03;
   localparam logic [OPC_W-1:0] OP_XOR    = 6'h04;
   localparam logic [OPC_W-1:0] OP_NOT    = 6'h05;
   localparam logic [OPC_W-1:0] OP_PASS_A = 6'h06;
   localparam logic [OPC_W-1:0] OP_PASS_B = 6'h07;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu.sv
// Element-wise ALU: ww selects element width (byte, half, word, double) for add/sub.
module alu
   import exmem_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OPC_W-1:0]  op_code,
   input  logic [1:0]        ww,
   output logic [DATA_W-1:0] result
);

   localparam int unsigned NB = DATA_W / 8;

   logic [8:0]  sum;
   logic [7:0]  b_byte;
   logic        carry;
   logic        sub;
   int unsigned ebytes;

   // Byte-lane ripple; carry chain restarts at the low byte of each element
   always_comb begin
      result = '0;
      sum    = '0;
      b_byte = '0;
      carry  = 1'b0;
      sub    = (op_code == OP_SUB);
      ebytes = 32'(1) << ww;
      case (op_code)
         OP_ADD, OP_SUB: begin
            for (int unsigned j = 0; j < NB; j++) begin
               if ((j % ebytes) == 0) carry = sub;
               b_byte = sub ? ~b[8*j +: 8] : b[8*j +: 8];
               sum    = 9'(a[8*j +: 8]) + 9'(b_byte) + 9'(carry);
               result[8*j +: 8] = sum[7:0];
               carry  = sum[8];
            end
         end
         OP_AND:    result = a & b;
         OP_OR:     result = a | b;
         OP_XOR:    result = a ^ b;
         OP_NOT:    result = ~a;
         OP_PASS_A: result = a;
         OP_PASS_B: result = b;
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/forward_merge.sv
// Merges WB write data into one register-file operand under the partial-write mode.
// Field numbering is MSB-first: byte 0 / upper half sit at the high-order end of the vector.
module forward_merge
   import exmem_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic [DATA_W-1:0] reg_data,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              fwd,
   input  logic [PPP_W-1:0]  ppp,
   output logic [DATA_W-1:0] merged
);

   localparam int unsigned NB = DATA_W / 8;

   logic [DATA_W-1:0] mask;
   logic              sel;

   // j indexes bytes from the LSB end; NB-1-j is the MSB-first byte number
   always_comb begin
      mask = '0;
      sel  = 1'b0;
      for (int unsigned j = 0; j < NB; j++) begin
         sel = 1'b0;
         case (ppp)
            PPP_FULL: sel = 1'b1;
            PPP_HI:   sel = (j >= NB / 2);
            PPP_LO:   sel = (j < NB / 2);
            PPP_EVEN: sel = (((NB - 1 - j) % 2) == 0);
            PPP_ODD:  sel = (((NB - 1 - j) % 2) == 1);
            default:  sel = 1'b0;
         endcase
         mask[8*j +: 8] = {8{sel}};
      end
   end

   assign merged = fwd ? ((wb_data & mask) | (reg_data & ~mask)) : reg_data;

endmodule

// File: rtl/exmem_pipe.sv
// EX/MEM stage: WB forwarding into the ALU and store path, plus the multi-cycle load stall FSM.
module exmem_pipe
   import exmem_pipe_pkg::*;
#(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned LOAD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] rA_data,
   input  logic [DATA_W-1:0] rB_data,
   input  logic [OPC_W-1:0]  op_code,
   input  logic [1:0]        ww,
   input  logic              wr_en,
   input  logic              mem_en,
   input  logic              mem_wr_en,
   input  logic              fwd_rA,
   input  logic              fwd_rB,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [PPP_W-1:0]  wb_ppp,
   output logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_req,
   output logic              stall,
   output logic              rd_sel,
   output logic [CNT_W-1:0]  load_cnt
);

   localparam logic [CNT_W-1:0] LAT_M1     = CNT_W'(LOAD_LAT - 1);
   localparam state_t           FIRST_NEXT = (LOAD_LAT > 1) ? S_WAIT : S_DONE;

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              is_load;
   logic              is_store;
   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;

   forward_merge #(.DATA_W(DATA_W)) u_fwd_a (
      .reg_data (rA_data),
      .wb_data  (wb_data),
      .fwd      (fwd_rA),
      .ppp      (wb_ppp),
      .merged   (op_a)
   );

   forward_merge #(.DATA_W(DATA_W)) u_fwd_b (
      .reg_data (rB_data),
      .wb_data  (wb_data),
      .fwd      (fwd_rB),
      .ppp      (wb_ppp),
      .merged   (op_b)
   );

   alu #(.DATA_W(DATA_W)) u_alu (
      .a       (op_a),
      .b       (op_b),
      .op_code (op_code),
      .ww      (ww),
      .result  (alu_out)
   );

   assign mem_data_in = op_b;
   assign is_load     = mem_en & wr_en & ~mem_wr_en;
   assign is_store    = mem_en & mem_wr_en & ~wr_en;
   assign load_cnt    = cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Control outputs are Mealy: a load stalls in the very cycle it is decoded
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      stall   = 1'b0;
      mem_req = 1'b0;
      rd_sel  = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_n = '0;
            if (is_load) begin
               stall   = 1'b1;
               mem_req = 1'b1;
               cnt_n   = LAT_M1;
               state_n = FIRST_NEXT;
            end
         end
         S_WAIT: begin
            if (!is_load) begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end else begin
               stall = 1'b1;
               cnt_n = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state_n = S_DONE;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
      if (is_store) mem_req = 1'b1;
      rd_sel = (state == S_DONE) | is_load;
      // Quiet the pipeline controls while reset is being applied
      if (reset) begin
         stall   = 1'b0;
         mem_req = 1'b0;
         rd_sel  = 1'b0;
      end
   end

endmodule

// File: tb/tb_exmem_pipe.sv
// Directed bench for exmem_pipe: forwarding fields, ALU path, store strobe, load stall timing at 1/2/4.
module tb_exmem_pipe;
   import exmem_pipe_pkg::*;

   localparam int unsigned W = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  rA_data = '0, rB_data = '0, wb_data = '0;
   logic [5:0]    op_code = OP_PASS_A;
   logic [1:0]    ww = 2'b11;
   logic          wr_en = 1'b0, mem_en = 1'b0, mem_wr_en = 1'b0;
   logic          fwd_rA = 1'b0, fwd_rB = 1'b0;
   logic [2:0]    wb_ppp = 3'b000;

   logic [W-1:0]  alu2, md2, alu1, md1, alu4, md4;
   logic          mr2, st2, rs2, mr1, st1, rs1, mr4, st4, rs4;
   logic [2:0]    lc2, lc1, lc4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exmem_pipe #(.DATA_W(W), .LOAD_LAT(2)) u2 (
      .clk(clk), .reset(reset), .rA_data(rA_data), .rB_data(rB_data), .op_code(op_code), .ww(ww),
      .wr_en(wr_en), .mem_en(mem_en), .mem_wr_en(mem_wr_en), .fwd_rA(fwd_rA), .fwd_rB(fwd_rB),
      .wb_data(wb_data), .wb_ppp(wb_ppp), .alu_out(alu2), .mem_data_in(md2), .mem_req(mr2),
      .stall(st2), .rd_sel(rs2), .load_cnt(lc2));

   exmem_pipe #(.DATA_W(W), .LOAD_LAT(1)) u1 (
      .clk(clk), .reset(reset), .rA_data(rA_data), .rB_data(rB_data), .op_code(op_code), .ww(ww),
      .wr_en(wr_en), .mem_en(mem_en), .mem_wr_en(mem_wr_en), .fwd_rA(fwd_rA), .fwd_rB(fwd_rB),
      .wb_data(wb_data), .wb_ppp(wb_ppp), .alu_out(alu1), .mem_data_in(md1), .mem_req(mr1),
      .stall(st1), .rd_sel(rs1), .load_cnt(lc1));

   exmem_pipe #(.DATA_W(W), .LOAD_LAT(4)) u4 (
      .clk(clk), .reset(reset), .rA_data(rA_data), .rB_data(rB_data), .op_code(op_code), .ww(ww),
      .wr_en(wr_en), .mem_en(mem_en), .mem_wr_en(mem_wr_en), .fwd_rA(fwd_rA), .fwd_rB(fwd_rB),
      .wb_data(wb_data), .wb_ppp(wb_ppp), .alu_out(alu4), .mem_data_in(md4), .mem_req(mr4),
      .stall(st4), .rd_sel(rs4), .load_cnt(lc4));

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load(input logic on);
      mem_en    = on;
      wr_en     = on;
      mem_wr_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_load(1'b0);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      bit       e_st2 [6] = '{1, 1, 0, 1, 1, 0};
      bit       e_mr2 [6] = '{1, 0, 0, 1, 0, 0};
      int       e_lc2 [6] = '{0, 1, 0, 0, 1, 0};
      bit       e_st4 [5] = '{1, 1, 1, 1, 0};
      int       e_lc4 [5] = '{0, 3, 2, 1, 0};
      bit       e_mr4 [5] = '{1, 0, 0, 0, 0};

      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_stall",   W'(st2), W'(0));
      chk("rst_mem_req", W'(mr2), W'(0));
      chk("rst_rd_sel",  W'(rs2), W'(0));
      chk("rst_cnt",     W'(lc2), W'(0));

      // Forwarding field selection on operand A, observed through pass-A
      op_code = OP_PASS_A; rA_data = '0; wb_data = '1; fwd_rA = 1'b1;
      wb_ppp = 3'b011; #1 chk("fwd_even", alu2, 64'hFF00FF00FF00FF00);
      wb_ppp = 3'b100; #1 chk("fwd_odd",  alu2, 64'h00FF00FF00FF00FF);
      wb_ppp = 3'b010; #1 chk("fwd_lo",   alu2, 64'h00000000FFFFFFFF);
      wb_ppp = 3'b001; #1 chk("fwd_hi",   alu2, 64'hFFFFFFFF00000000);
      wb_ppp = 3'b111; #1 chk("fwd_none", alu2, 64'h0);
      wb_ppp = 3'b000; #1 chk("fwd_full", alu2, 64'hFFFFFFFFFFFFFFFF);
      fwd_rA = 1'b0;   #1 chk("fwd_off",  alu2, 64'h0);

      op_code = OP_PASS_B; rB_data = 64'hAAAAAAAAAAAAAAAA; wb_data = '0; fwd_rB = 1'b1; wb_ppp = 3'b001;
      #1 chk("fwdB_hi", alu2, 64'h00000000AAAAAAAA);
      fwd_rB = 1'b0;

      // ALU element widths
      op_code = OP_ADD; ww = 2'b11; rA_data = 64'd5; rB_data = 64'd7;
      #1 chk("add_d", alu2, 64'd12);
      op_code = OP_SUB; rA_data = 64'd12; rB_data = 64'd5;
      #1 chk("sub_d", alu2, 64'd7);
      op_code = OP_ADD; ww = 2'b00; rA_data = 64'h00FF; rB_data = 64'h0001;
      #1 chk("add_b", alu2, 64'h0000);
      ww = 2'b01;
      #1 chk("add_h", alu2, 64'h0100);
      ww = 2'b11;

      // Store with forwarded store data
      mem_en = 1'b1; mem_wr_en = 1'b1; wr_en = 1'b0;
      fwd_rB = 1'b1; wb_ppp = 3'b000; wb_data = 64'h1234; rB_data = 64'hDEAD;
      #1;
      chk("st_data",    md2, 64'h1234);
      chk("st_mem_req", W'(mr2), W'(1));
      chk("st_stall",   W'(st2), W'(0));
      chk("st_rd_sel",  W'(rs2), W'(0));
      tick();
      mem_en = 1'b0; mem_wr_en = 1'b0; fwd_rB = 1'b0;
      #1 chk("st_req_drop", W'(mr2), W'(0));

      // LAT=2 back-to-back loads held for six cycles
      do_reset();
      set_load(1'b1);
      op_code = OP_PASS_A; rA_data = '0; wb_data = '1;
      for (int i = 0; i < 6; i++) begin
         fwd_rA = (i == 1); wb_ppp = 3'b001;
         #1;
         chk($sformatf("l2_stall%0d", i), W'(st2), W'(e_st2[i]));
         chk($sformatf("l2_req%0d", i),   W'(mr2), W'(e_mr2[i]));
         chk($sformatf("l2_cnt%0d", i),   W'(lc2), W'(e_lc2[i]));
         chk($sformatf("l2_rdsel%0d", i), W'(rs2), W'(1));
         if (i == 1) chk("fwd_in_stall", alu2, 64'hFFFFFFFF00000000);
         tick();
      end
      set_load(1'b0); fwd_rA = 1'b0;
      #1 chk("l2_idle_rdsel", W'(rs2), W'(0));

      // LAT=1 single-cycle stall
      do_reset();
      set_load(1'b1);
      #1;
      chk("l1_stall0", W'(st1), W'(1));
      chk("l1_req0",   W'(mr1), W'(1));
      tick();
      set_load(1'b0);
      #1;
      chk("l1_stall1", W'(st1), W'(0));
      chk("l1_rdsel1", W'(rs1), W'(1));
      tick();
      chk("l1_rdsel2", W'(rs1), W'(0));

      // LAT=4 abort when decode drops mid-WAIT
      do_reset();
      set_load(1'b1);
      tick();
      chk("ab_wait_stall", W'(st4), W'(1));
      tick();
      set_load(1'b0);
      #1 chk("ab_stall", W'(st4), W'(0));
      tick();
      chk("ab_cnt",  W'(lc4), W'(0));
      chk("ab_idle", W'(st4), W'(0));

      // LAT=4 reset in second WAIT cycle, then a full-length load
      do_reset();
      set_load(1'b1);
      tick();
      chk("rw_cnt1", W'(lc4), W'(3));
      tick();
      chk("rw_cnt2", W'(lc4), W'(2));
      reset = 1'b1;
      tick();
      reset = 1'b0; set_load(1'b0);
      #1;
      chk("rw_stall", W'(st4), W'(0));
      chk("rw_cnt",   W'(lc4), W'(0));
      chk("rw_req",   W'(mr4), W'(0));
      tick();
      set_load(1'b1);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("l4_stall%0d", i), W'(st4), W'(e_st4[i]));
         chk($sformatf("l4_cnt%0d", i),   W'(lc4), W'(e_lc4[i]));
         chk($sformatf("l4_req%0d", i),   W'(mr4), W'(e_mr4[i]));
         tick();
      end
      set_load(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
